// File: rtl/vs_spi_master.sv
// SPI master for a VS10xx-style audio decoder: queued SCI register writes
// and DREQ-paced SDI byte bursts on a shared SCK/SI pair.
module vs_spi_master #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned BURST_BYTES = 32,
  parameter int unsigned CMD_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_DREQ,
  input  logic        i_pause,
  input  logic        i_cmd_valid,
  input  logic [7:0]  i_cmd_addr,
  input  logic [15:0] i_cmd_data,
  output logic        o_cmd_ready,
  input  logic        i_dat_valid,
  input  logic [7:0]  i_dat_byte,
  output logic        o_dat_ready,
  output logic        o_XCS,
  output logic        o_XDCS,
  output logic        o_SCK,
  output logic        o_SI,
  output logic        o_busy,
  output logic        o_sci_done
);

  localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BYTE_W = $clog2(BURST_BYTES + 1);
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE, SCI_SETUP, SCI_SHIFT, SCI_HOLD, SDI_SETUP, SDI_SHIFT, SDI_HOLD, GAP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              phase, phase_n;
  logic [4:0]        bit_cnt, bit_n;
  logic [31:0]       shreg, shreg_n;
  logic [BYTE_W-1:0] byte_cnt, byte_n;
  logic              last;
  logic              dreq_m, dreq_s;
  logic              xcs_n, xdcs_n, sck_n, si_n, dat_ready_n, sci_done_n, busy_n;

  logic [23:0]       mem [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill, fill_n;
  logic              push, pop, empty;

  assign push  = i_cmd_valid & o_cmd_ready;
  assign empty = (fill == '0);
  assign last  = (cnt == CNT_W'(CLK_DIV - 1));

  // Two-flop synchroniser for the decoder's asynchronous DREQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreq_m <= 1'b0;
      dreq_s <= 1'b0;
    end else begin
      dreq_m <= i_DREQ;
      dreq_s <= dreq_m;
    end
  end

  // Command FIFO occupancy after this cycle's push/pop
  always_comb begin
    fill_n = fill;
    if (push && !pop)      fill_n = fill + FILL_W'(1);
    else if (!push && pop) fill_n = fill - FILL_W'(1);
  end

  // Command FIFO pointers, fill level and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      o_cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fill        <= fill_n;
      o_cmd_ready <= (fill_n != FILL_W'(CMD_DEPTH));
    end
  end

  // Command FIFO storage, {addr, data}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_cmd_addr, i_cmd_data};
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    phase_n     = phase;
    bit_n       = bit_cnt;
    shreg_n     = shreg;
    byte_n      = byte_cnt;
    pop         = 1'b0;
    dat_ready_n = 1'b0;
    sci_done_n  = 1'b0;

    if (state != IDLE) cnt_n = last ? '0 : cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        phase_n = 1'b0;
        if (!empty && dreq_s) begin
          state_n = SCI_SETUP;
          pop     = 1'b1;
          shreg_n = {8'h02, mem[rd_ptr]};
          bit_n   = 5'd31;
        end else if (i_dat_valid && dreq_s && !i_pause) begin
          state_n     = SDI_SETUP;
          dat_ready_n = 1'b1;
          shreg_n     = {i_dat_byte, 24'h0};
          bit_n       = 5'd7;
          byte_n      = BYTE_W'(1);
        end
      end
      SCI_SETUP: if (last) state_n = SCI_SHIFT;
      SDI_SETUP: if (last) state_n = SDI_SHIFT;
      SCI_SHIFT, SDI_SHIFT: begin
        if (last) begin
          phase_n = ~phase;
          if (phase) begin
            if (bit_cnt != 5'd0) begin
              bit_n   = bit_cnt - 5'd1;
              shreg_n = {shreg[30:0], 1'b0};
            end else if (state == SCI_SHIFT) begin
              state_n = SCI_HOLD;
            end else if (byte_cnt < BYTE_W'(BURST_BYTES) && i_dat_valid) begin
              dat_ready_n = 1'b1;
              shreg_n     = {i_dat_byte, 24'h0};
              bit_n       = 5'd7;
              byte_n      = byte_cnt + BYTE_W'(1);
            end else begin
              state_n = SDI_HOLD;
            end
          end
        end
      end
      // phase 0: select still low; phase 1: select released before GAP
      SCI_HOLD, SDI_HOLD: begin
        if (last) begin
          if (!phase) begin
            phase_n = 1'b1;
          end else begin
            phase_n    = 1'b0;
            state_n    = GAP;
            sci_done_n = (state == SCI_HOLD);
          end
        end
      end
      GAP: if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    xcs_n  = !((state_n == SCI_SETUP) || (state_n == SCI_SHIFT) ||
               ((state_n == SCI_HOLD) && !phase_n));
    xdcs_n = !((state_n == SDI_SETUP) || (state_n == SDI_SHIFT) ||
               ((state_n == SDI_HOLD) && !phase_n));
    sck_n  = ((state_n == SCI_SHIFT) || (state_n == SDI_SHIFT)) && phase_n;
    si_n   = (state_n inside {SCI_SETUP, SCI_SHIFT, SDI_SETUP, SDI_SHIFT}) ? shreg_n[31] : 1'b0;
    busy_n = (state_n != IDLE);
  end

  // FSM state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      phase       <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_cnt    <= '0;
      o_XCS       <= 1'b1;
      o_XDCS      <= 1'b1;
      o_SCK       <= 1'b0;
      o_SI        <= 1'b0;
      o_dat_ready <= 1'b0;
      o_busy      <= 1'b0;
      o_sci_done  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      phase       <= phase_n;
      bit_cnt     <= bit_n;
      shreg       <= shreg_n;
      byte_cnt    <= byte_n;
      o_XCS       <= xcs_n;
      o_XDCS      <= xdcs_n;
      o_SCK       <= sck_n;
      o_SI        <= si_n;
      o_dat_ready <= dat_ready_n;
      o_busy      <= busy_n;
      o_sci_done  <= sci_done_n;
    end
  end

endmodule

// File: tb/tb_vs_spi_master.sv
// Bench for vs_spi_master: scoreboard of expected SCI words / SDI bytes
// checked against a serial monitor, plus frame timing and ordering checks.
module tb_vs_spi_master;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned BURST_BYTES = 32;
  localparam int unsigned CMD_DEPTH   = 4;
  localparam logic [7:0]  RST_PAT     = 8'b1100_0001; // XCS XDCS SCK SI drdy busy done crdy

  logic        clk = 1'b0;
  logic        rst_n, i_DREQ, i_pause, i_cmd_valid, i_dat_valid;
  logic [7:0]  i_cmd_addr, i_dat_byte;
  logic [15:0] i_cmd_data;
  logic        o_cmd_ready, o_dat_ready, o_XCS, o_XDCS, o_SCK, o_SI, o_busy, o_sci_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_sci[$];
  logic [7:0]  exp_sdi[$];
  logic [7:0]  src[$];
  logic [7:0]  log_q[$];
  int          sci_len_q[$], sdi_len_q[$], burst_q[$], ready_q[$], gap_q[$];
  int          sci_frames = 0, sci_done_cnt = 0, overlap = 0, mon_sci_bits = 0;
  logic        src_en = 1'b0;

  vs_spi_master #(.CLK_DIV(CLK_DIV), .BURST_BYTES(BURST_BYTES), .CMD_DEPTH(CMD_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_DREQ(i_DREQ), .i_pause(i_pause),
    .i_cmd_valid(i_cmd_valid), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_cmd_ready(o_cmd_ready), .i_dat_valid(i_dat_valid), .i_dat_byte(i_dat_byte),
    .o_dat_ready(o_dat_ready), .o_XCS(o_XCS), .o_XDCS(o_XDCS), .o_SCK(o_SCK),
    .o_SI(o_SI), .o_busy(o_busy), .o_sci_done(o_sci_done)
  );

  always #5 clk = ~clk;

  // SDI byte source: head byte presented until the DUT strobes o_dat_ready
  initial begin
    i_dat_valid = 1'b0;
    i_dat_byte  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (o_dat_ready && src.size() > 0) exp_sdi.push_back(src.pop_front());
      i_dat_valid = src_en && (src.size() > 0);
      i_dat_byte  = (src.size() > 0) ? src[0] : 8'h00;
    end
  end

  // Serial monitor: rebuilds frames on SCK rising edges and times selects
  initial begin
    logic        sck_q, xcs_q, xdcs_q, any_q, any_low, seen;
    logic [31:0] sci_word, exp_w;
    logic [7:0]  sdi_byte, exp_b;
    int          sdi_bits, xcs_len, xdcs_len, burst_cnt, ready_cnt, gap_cnt;
    sck_q = 1'b0; xcs_q = 1'b1; xdcs_q = 1'b1; any_q = 1'b0; seen = 1'b0;
    sci_word = '0; sdi_byte = '0; sdi_bits = 0; xcs_len = 0; xdcs_len = 0;
    burst_cnt = 0; ready_cnt = 0; gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sck_q = 1'b0; xcs_q = 1'b1; xdcs_q = 1'b1; any_q = 1'b0; seen = 1'b0;
        sci_word = '0; sdi_byte = '0; sdi_bits = 0; mon_sci_bits = 0;
        xcs_len = 0; xdcs_len = 0; burst_cnt = 0; ready_cnt = 0; gap_cnt = 0;
      end else begin
        any_low = !o_XCS || !o_XDCS;
        if (!o_XCS && !o_XDCS) overlap++;
        if (o_sci_done) sci_done_cnt++;
        if (any_low && !any_q) begin
          if (seen) gap_q.push_back(gap_cnt);
          log_q.push_back(!o_XCS ? 8'h43 : 8'h44);
        end
        if (!any_low && any_q) begin
          seen = 1'b1;
          gap_cnt = 0;
        end
        if (!any_low) gap_cnt++;
        if (o_SCK && !sck_q) begin
          if (!o_XCS) begin
            sci_word = {sci_word[30:0], o_SI};
            mon_sci_bits++;
          end
          if (!o_XDCS) begin
            sdi_byte = {sdi_byte[6:0], o_SI};
            sdi_bits++;
            if (sdi_bits == 8) begin
              checks++;
              if (exp_sdi.size() == 0) begin
                errors++;
                $display("FAIL sdi_byte got %02h expected none", sdi_byte);
              end else begin
                exp_b = exp_sdi.pop_front();
                if (sdi_byte !== exp_b) begin
                  errors++;
                  $display("FAIL sdi_byte got %02h expected %02h", sdi_byte, exp_b);
                end
              end
              sdi_bits = 0;
              burst_cnt++;
            end
          end
        end
        if (!o_XCS) xcs_len++;
        if (!o_XDCS) begin
          xdcs_len++;
          if (o_dat_ready) ready_cnt++;
        end
        if (o_XCS && !xcs_q) begin
          checks++;
          if (exp_sci.size() == 0) begin
            errors++;
            $display("FAIL sci_frame got %08h expected none", sci_word);
          end else begin
            exp_w = exp_sci.pop_front();
            if (sci_word !== exp_w || mon_sci_bits != 32) begin
              errors++;
              $display("FAIL sci_frame got %08h (%0d bits) expected %08h (32 bits)",
                       sci_word, mon_sci_bits, exp_w);
            end
          end
          sci_len_q.push_back(xcs_len);
          sci_frames++;
          xcs_len = 0; sci_word = '0; mon_sci_bits = 0;
        end
        if (o_XDCS && !xdcs_q) begin
          sdi_len_q.push_back(xdcs_len);
          burst_q.push_back(burst_cnt);
          ready_q.push_back(ready_cnt);
          xdcs_len = 0; burst_cnt = 0; ready_cnt = 0; sdi_bits = 0;
        end
        sck_q = o_SCK; xcs_q = o_XCS; xdcs_q = o_XDCS; any_q = any_low;
      end
    end
  end

  task automatic push_cmd(input logic [7:0] a, input logic [15:0] d, output logic acc);
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_data  = d;
    acc = o_cmd_ready;
    if (acc) exp_sci.push_back({8'h02, a, d});
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!o_busy && src.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (o_busy || src.size() != 0) begin
      errors++;
      $display("FAIL %s idle_timeout busy=%0b src_left=%0d required busy=0 src_left=0",
               name, o_busy, src.size());
    end
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b0; i_DREQ = 1'b0; i_pause = 1'b0; i_cmd_valid = 1'b0;
    i_cmd_addr = 8'h00; i_cmd_data = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_XCS, o_XDCS, o_SCK, o_SI, o_dat_ready, o_busy, o_sci_done, o_cmd_ready} !== RST_PAT) begin
      errors++;
      $display("FAIL reset_outputs got %b required %b",
               {o_XCS, o_XDCS, o_SCK, o_SI, o_dat_ready, o_busy, o_sci_done, o_cmd_ready}, RST_PAT);
    end
    rst_n = 1'b1;
    push_cmd(8'h0B, 16'h2020, acc);
    repeat (20) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_XCS !== 1'b1 || acc !== 1'b1) begin
      errors++;
      $display("FAIL no_dreq_hold got busy=%0b xcs=%0b acc=%0b required 0 1 1", o_busy, o_XCS, acc);
    end
  endtask

  task automatic test_sci_single();
    int lat, f0, d0;
    f0 = sci_frames; d0 = sci_done_cnt; lat = 0;
    @(negedge clk);
    i_DREQ = 1'b1;
    while (o_XCS && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat < 2 || lat > 4) begin
      errors++;
      $display("FAIL dreq_latency got %0d cycles required 2..4", lat);
    end
    for (int i = 0; i < 400 && sci_frames == f0; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    checks++;
    if (sci_frames != f0 + 1 || sci_len_q.size() == 0) begin
      errors++;
      $display("FAIL sci_single frames got %0d required %0d", sci_frames - f0, 1);
    end else if (sci_len_q[$] != 66 * CLK_DIV) begin
      errors++;
      $display("FAIL sci_len got %0d required %0d", sci_len_q[$], 66 * CLK_DIV);
    end
    checks++;
    if (sci_done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL sci_done_pulses got %0d required 1", sci_done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] acc;
    logic a;
    int f0;
    i_DREQ = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push_cmd(8'h10 + 8'(i), 16'hA500 + 16'(i * 17), a);
      acc[i] = a;
    end
    @(negedge clk);
    checks++;
    if (acc !== 5'b01111 || o_cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full got acc=%b ready=%0b required acc=01111 ready=0", acc, o_cmd_ready);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_dreq_busy got %0b required 0", o_busy);
    end
    gap_q.delete();
    sci_len_q.delete();
    f0 = sci_frames;
    i_DREQ = 1'b1;
    for (int i = 0; i < 2000 && sci_frames < f0 + 4; i++) @(negedge clk);
    checks++;
    if (sci_frames != f0 + 4 || gap_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_frames got %0d gaps=%0d required 4 gaps=4", sci_frames - f0, gap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sci_len_q[i] != 66 * CLK_DIV) begin
          errors++;
          $display("FAIL b2b_len%0d got %0d required %0d", i, sci_len_q[i], 66 * CLK_DIV);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (gap_q[i] < 2 * CLK_DIV) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d required >=%0d", i, gap_q[i], 2 * CLK_DIV);
        end
      end
    end
    wait_idle("b2b");
  endtask

  task automatic test_sdi_burst();
    burst_q.delete(); ready_q.delete(); sdi_len_q.delete(); gap_q.delete();
    for (int i = 0; i < 40; i++) src.push_back(8'($urandom_range(0, 255)));
    src_en = 1'b1;
    for (int i = 0; i < 3000 && burst_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (burst_q.size() < 2 || gap_q.size() < 2) begin
      errors++;
      $display("FAIL sdi_bursts got %0d bursts required 2", burst_q.size());
    end else begin
      checks++;
      if (burst_q[0] != BURST_BYTES || ready_q[0] != BURST_BYTES) begin
        errors++;
        $display("FAIL burst0_bytes got %0d strobes=%0d required %0d", burst_q[0], ready_q[0], BURST_BYTES);
      end
      checks++;
      if (sdi_len_q[0] != (16 * BURST_BYTES + 2) * CLK_DIV) begin
        errors++;
        $display("FAIL burst0_len got %0d required %0d", sdi_len_q[0], (16 * BURST_BYTES + 2) * CLK_DIV);
      end
      checks++;
      if (gap_q[1] < 2 * CLK_DIV) begin
        errors++;
        $display("FAIL burst_gap got %0d required >=%0d", gap_q[1], 2 * CLK_DIV);
      end
      checks++;
      if (burst_q[1] != 8 || sdi_len_q[1] != (16 * 8 + 2) * CLK_DIV) begin
        errors++;
        $display("FAIL burst1 got %0d bytes len=%0d required 8 len=%0d",
                 burst_q[1], sdi_len_q[1], (16 * 8 + 2) * CLK_DIV);
      end
    end
    wait_idle("sdi_burst");
  endtask

  task automatic test_short_burst();
    int n0;
    burst_q.delete(); ready_q.delete(); sdi_len_q.delete();
    for (int i = 0; i < 5; i++) src.push_back(8'h30 + 8'(i * 37));
    for (int i = 0; i < 1000 && burst_q.size() < 1; i++) @(negedge clk);
    n0 = log_q.size();
    repeat (100) @(negedge clk);
    checks++;
    if (burst_q.size() != 1 || ready_q.size() != 1) begin
      errors++;
      $display("FAIL short_bursts got %0d required 1", burst_q.size());
    end else if (burst_q[0] != 5 || ready_q[0] != 5 || sdi_len_q[0] != (16 * 5 + 2) * CLK_DIV) begin
      errors++;
      $display("FAIL short_burst got %0d bytes strobes=%0d len=%0d required 5 5 %0d",
               burst_q[0], ready_q[0], sdi_len_q[0], (16 * 5 + 2) * CLK_DIV);
    end
    checks++;
    if (log_q.size() != n0 || o_XDCS !== 1'b1) begin
      errors++;
      $display("FAIL short_after got %0d new frames xdcs=%0b required 0 1", log_q.size() - n0, o_XDCS);
    end
  endtask

  task automatic test_cmd_during_sdi();
    logic acc;
    int base, f0, nd;
    base = log_q.size();
    for (int i = 0; i < 40; i++) src.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 200 && o_XDCS; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    push_cmd(8'h05, 16'hAC45, acc);
    for (int i = 0; i < 4000 && log_q.size() < base + 3; i++) @(negedge clk);
    checks++;
    if (log_q.size() < base + 3) begin
      errors++;
      $display("FAIL sdi_sci_order got %0d frames required 3", log_q.size() - base);
    end else if (log_q[base] !== 8'h44 || log_q[base + 1] !== 8'h43 || log_q[base + 2] !== 8'h44) begin
      errors++;
      $display("FAIL sdi_sci_order got %c%c%c required DCD", log_q[base], log_q[base + 1], log_q[base + 2]);
    end
    wait_idle("cmd_during_sdi");
    i_pause = 1'b1;
    repeat (4) @(negedge clk);
    base = log_q.size();
    f0 = sci_frames;
    for (int i = 0; i < 10; i++) src.push_back(8'hC0 + 8'(i));
    push_cmd(8'h03, 16'h9800, acc);
    push_cmd(8'h0C, 16'h0004, acc);
    for (int i = 0; i < 2000 && sci_frames < f0 + 2; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    nd = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i] == 8'h44) nd++;
    checks++;
    if (nd != 0 || sci_frames != f0 + 2 || src.size() != 10) begin
      errors++;
      $display("FAIL pause got sdi=%0d sci=%0d src_left=%0d required 0 2 10", nd, sci_frames - f0, src.size());
    end
    burst_q.delete();
    i_pause = 1'b0;
    wait_idle("pause_release");
    checks++;
    if (burst_q.size() != 1 || burst_q[0] != 10) begin
      errors++;
      $display("FAIL pause_release got %0d bursts required 1 burst of 10", burst_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic acc;
    int f0, n0;
    src_en = 1'b0;
    push_cmd(8'h01, 16'h1234, acc);
    push_cmd(8'h02, 16'h5678, acc);
    push_cmd(8'h03, 16'h9ABC, acc);
    for (int i = 0; i < 500 && mon_sci_bits != 12; i++) @(negedge clk);
    checks++;
    if (mon_sci_bits != 12) begin
      errors++;
      $display("FAIL reach_bit12 got %0d bits required 12", mon_sci_bits);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_XCS, o_XDCS, o_SCK, o_SI, o_dat_ready, o_busy, o_sci_done, o_cmd_ready} !== RST_PAT) begin
      errors++;
      $display("FAIL midframe_reset got %b required %b",
               {o_XCS, o_XDCS, o_SCK, o_SI, o_dat_ready, o_busy, o_sci_done, o_cmd_ready}, RST_PAT);
    end
    exp_sci.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = sci_frames;
    n0 = log_q.size();
    repeat (300) @(negedge clk);
    checks++;
    if (sci_frames != f0 || log_q.size() != n0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_flushed got frames=%0d busy=%0b ready=%0b required 0 0 1",
               log_q.size() - n0, o_busy, o_cmd_ready);
    end
  endtask

  task automatic test_final();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL cs_overlap got %0d cycles required 0", overlap);
    end
    checks++;
    if (exp_sci.size() != 0 || exp_sdi.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got sci=%0d sdi=%0d required 0 0", exp_sci.size(), exp_sdi.size());
    end
  endtask

  initial begin
    test_reset();
    test_sci_single();
    test_back_to_back();
    test_sdi_burst();
    test_short_burst();
    test_cmd_during_sdi();
    test_reset_mid_frame();
    test_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vs_spi_master.md
VS_SPI_MASTER -- requirements
Module: vs_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SCK half-period in clk cycles (>=1).
REQ-002 Parameter BURST_BYTES, default 32, max SDI bytes per DREQ grant (>=1).
REQ-003 Parameter CMD_DEPTH, default 4, SCI command FIFO depth (power of 2, >=2).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_DREQ  input  1  decoder data request, asynchronous to clk.
REQ-007 i_pause  input  1  high blocks start of new SDI bursts.
REQ-008 i_cmd_valid  input  1  SCI write request.
REQ-009 i_cmd_addr  input  8  SCI register address.
REQ-010 i_cmd_data  input  16  SCI register value.
REQ-011 o_cmd_ready  output  1  FIFO not full.
REQ-012 i_dat_valid  input  1  SDI byte available.
REQ-013 i_dat_byte  input  8  SDI byte.
REQ-014 o_dat_ready  output  1  one-cycle byte-accept strobe.
REQ-015 o_XCS, o_XDCS  output  1 each  SCI / SDI chip selects, active low.
REQ-016 o_SCK  output  1  serial clock, mode 0 (idle low).
REQ-017 o_SI  output  1  serial data, MSB first.
REQ-018 o_busy  output  1  high whenever FSM not IDLE.
REQ-019 o_sci_done  output  1  one-cycle pulse at SCI frame completion.

Function
REQ-020 i_DREQ shall pass a 2-flop synchroniser; all decisions use the synchronised value (dreq_s).
REQ-021 Command FIFO: push on i_cmd_valid & o_cmd_ready storing {addr,data}; o_cmd_ready = !full; push while full ignored; pop only at SCI frame load.
REQ-022 FSM states: IDLE, SCI_SETUP, SCI_SHIFT, SCI_HOLD, SDI_SETUP, SDI_SHIFT, SDI_HOLD, GAP.
REQ-023 IDLE: FIFO non-empty & dreq_s -> SCI_SETUP (pop, load shifter {8'h02,addr,data}); else i_dat_valid & dreq_s & !i_pause -> SDI_SETUP; else stay. SCI always wins simultaneous eligibility.
REQ-024 SETUP states: chip select low, SCK low, SI = bit 31 (SCI) / bit 7 (SDI), for CLK_DIV cycles.
REQ-025 Bit timing: SCK low CLK_DIV cycles then high CLK_DIV cycles per bit; SI changes only while SCK low, stable across rising edge.
REQ-026 SCI_SHIFT: 32 bits, then SCI_HOLD.
REQ-027 SDI_SETUP/SDI_SHIFT: byte accepted (o_dat_ready=1 one cycle) at load; 8 bits per byte; byte counter width $clog2(BURST_BYTES+1).
REQ-028 At SDI byte boundary: count < BURST_BYTES and i_dat_valid -> accept next byte, continue without deasserting o_XDCS; otherwise SDI_HOLD. dreq_s and i_pause not re-checked mid-burst.
REQ-029 HOLD states: SCK low, chip select held low CLK_DIV cycles, then released; SCI_HOLD exit pulses o_sci_done.
REQ-030 GAP: both selects high CLK_DIV cycles, then IDLE.
REQ-031 o_XCS and o_XDCS shall never be low simultaneously.
REQ-032 Frame durations: SCI = 66*CLK_DIV cycles from XCS fall to rise; SDI burst of N bytes = (16N+2)*CLK_DIV.
REQ-033 dreq_s falling during a frame/burst shall not truncate it.

Reset
REQ-034 rst_n low shall immediately force o_XCS=1, o_XDCS=1, o_SCK=0, o_SI=0, o_dat_ready=0, o_busy=0, o_sci_done=0, FSM IDLE, FIFO empty (o_cmd_ready=1), synchroniser 0.
REQ-035 Reset mid-frame aborts the frame; no partial resumption after release.
REQ-036 After rst_n rises, no frame starts before dreq_s is 1 (>=2 cycles).

Verification
REQ-037 CLK_DIV=2, DREQ=1, push {0x0B,0x2020} -> XCS low 132 cycles, SI sequence 0x020B2020 MSB first, o_sci_done one pulse.
REQ-038 Push 5 commands back-to-back with CMD_DEPTH=4, DREQ=0 -> 4 accepted, o_cmd_ready=0 on 5th; raise DREQ -> 4 frames in order, GAP between each.
REQ-039 BURST_BYTES=32, i_dat_valid constant, DREQ=1 -> 32 o_dat_ready strobes per XDCS low window, XDCS high >=2*CLK_DIV between bursts.
REQ-040 i_dat_valid drops after byte 5 -> burst ends after 5 bytes, XDCS rises after SDI_HOLD.
REQ-041 Command pushed during SDI burst -> burst completes, SCI frame next before further SDI; i_pause=1 -> only SCI frames issued.
REQ-042 rst_n low mid-SCI bit 12 -> outputs at reset values same cycle, FIFO empty after release.
